sipo_deser: RTL

- Serial-in, parallel-out deserializer. It sits directly downstream of the latch-based D flip-flop stage.
- Consumes the single-bit registered q stream as din, qualified by din_vld.
- Assembles WIDTH-bit words and presents each word on a valid/ready output register.
- Provides overflow detection and a synchronous frame clear.

---
 rtl/sipo_deser_if.sv | 24 ++
 rtl/sipo_deser.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sipo_deser_if.sv
// Output word channel of the serial-in, parallel-out deserializer.
// The master side presents an assembled word and its parity flag, and the slave side returns ready.
interface sipo_deser_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic             par_err;

    modport master (
        output dout,
        output dout_vld,
        output par_err,
        input  dout_rdy
    );

    modport slave (
        input  dout,
        input  dout_vld,
        input  par_err,
        output dout_rdy
    );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer. It assembles WIDTH-bit words from a qualified bit stream.
// Define SIPO_PARITY_CHK_EN to expect an even-parity bit after each word and flag it on par_err.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_vld,
    input  logic          clr,
    sipo_deser_if.master  dbus,
    output logic          busy,
    output logic          ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SIPO_PARITY_CHK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             complete;
`ifdef SIPO_PARITY_CHK_EN
    logic             par_q, par_d;
`endif

    // Shift direction decides which end of the word the first bit lands in.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], din};
        end else begin
            shifted = {din, shreg_q[WIDTH-1:1]};
        end
    end

    // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        complete = 1'b0;
        vld_d    = vld_q & ~dbus.dout_rdy;
`ifdef SIPO_PARITY_CHK_EN
        par_d    = par_q;
`endif

        if (clr) begin
            cnt_d   = '0;
            shreg_d = '0;
            state_d = IDLE;
            ovf_d   = 1'b0;
        end else if (din_vld) begin
            case (state_q)
`ifdef SIPO_PARITY_CHK_EN
                PAR: begin
                    complete = 1'b1;
                    dout_d   = shreg_q;
                    par_d    = (^shreg_q) ^ din;
                    state_d  = IDLE;
                end
`endif
                default: begin
                    shreg_d = shifted;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
`ifdef SIPO_PARITY_CHK_EN
                        state_d = PAR;
`else
                        complete = 1'b1;
                        dout_d   = shifted;
                        state_d  = IDLE;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = SHIFT;
                    end
                end
            endcase
        end

        // A completing word always leaves a valid word. It is an overflow only if the old word was not taken.
        if (complete) begin
            vld_d = 1'b1;
            if (vld_q && !dbus.dout_rdy) begin
                ovf_d = 1'b1;
            end
        end

`ifdef SIPO_PARITY_CHK_EN
        busy_d = (cnt_d != '0) || (state_d == PAR);
`else
        busy_d = (cnt_d != '0);
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SIPO_PARITY_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign dbus.par_err = par_q;
`else
    assign dbus.par_err = 1'b0;
`endif

    assign dbus.dout     = dout_q;
    assign dbus.dout_vld = vld_q;
    assign busy          = busy_q;
    assign ovf           = ovf_q;

endmodule
